mig_seq_eval: RTL and testbench

- Programmable, sequential majority-inverter-graph (MIG) evaluator for classification of NUM_INPUTS-input Boolean functions.
- Holds a runtime-loaded netlist of NUM_GATES three-input majority gates with per-operand complement.
- Evaluates one gate per cycle, for a single input vector or as a full truth-table sweep over all 2^NUM_INPUTS vectors.
- Replaces hard-wired per-function majority netlists in the classification flow.

---
 rtl/mig_pkg.sv | 29 ++
 rtl/mig_gate_ram.sv | 33 +++
 rtl/mig_seq_eval.sv | 222 ++++++++++++++++++++++
 tb/tb_mig_seq_eval.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_pkg.sv
// Shared types for the sequential majority-inverter-graph evaluator.
// Selects are stored at a fixed maximum width so the gate record is parameter-free.
package mig_pkg;

    // Wide enough for 1 + 10 inputs + 64 gates = 75 select codes.
    localparam int SEL_MAX_W  = 7;
    localparam int SEL_CONST0 = 0;
    localparam int SEL_X_BASE = 1;

    typedef struct packed {
        logic [SEL_MAX_W-1:0] sel_c;
        logic [SEL_MAX_W-1:0] sel_b;
        logic [SEL_MAX_W-1:0] sel_a;
        logic                 inv_c;
        logic                 inv_b;
        logic                 inv_a;
    } gate_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mig_gate_ram.sv
// Gate netlist store: one configuration record per majority gate.
// Synchronous write, asynchronous read, cleared to all-const0 selects on reset.
module mig_gate_ram
    import mig_pkg::*;
#(
    parameter int NUM_GATES = 8,
    parameter int GA_W      = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [GA_W-1:0] wr_addr_i,
    input  gate_cfg_t       wr_data_i,
    input  logic [GA_W-1:0] rd_addr_i,
    output gate_cfg_t       rd_data_o
);

    gate_cfg_t mem_q [NUM_GATES];

    // Write one gate record; out-of-range addresses are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_GATES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(wr_addr_i) < NUM_GATES)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mig_seq_eval.sv
// Sequential MIG evaluator: one majority gate per cycle over a loaded netlist,
// for a single input vector or a full truth-table sweep.
module mig_seq_eval
    import mig_pkg::*;
#(
    parameter  int NUM_INPUTS = 7,
    parameter  int NUM_GATES  = 8,
    localparam int SEL_W      = $clog2(1 + NUM_INPUTS + NUM_GATES),
    localparam int GA_W       = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1,
    localparam int TT_W       = 2 ** NUM_INPUTS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [GA_W-1:0]       cfg_addr,
    input  logic [3*SEL_W-1:0]    cfg_sel,
    input  logic [2:0]            cfg_inv,
    input  logic [GA_W:0]         cfg_ngates,
    input  logic [SEL_W-1:0]      cfg_out_sel,
    input  logic                  cfg_out_inv,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [NUM_INPUTS-1:0] in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic [TT_W-1:0]       out_tt,
    output logic                  ref_err
);

    state_t                state_q;
    logic [GA_W:0]         g_q;
    logic [NUM_INPUTS-1:0] pat_q;
    logic                  mode_q;
    logic [NUM_GATES-1:0]  gv_q;
    logic [GA_W:0]         ngates_q;
    logic [SEL_W-1:0]      out_sel_q;
    logic                  out_inv_q;
    logic                  out_valid_q;
    logic                  out_bit_q;
    logic [TT_W-1:0]       out_tt_q;
    logic                  ref_err_q;
    logic                  in_ready_q;

    logic                  cfg_wr;
    gate_cfg_t             cfg_gc;
    gate_cfg_t             gc;
    logic [GA_W-1:0]       ga;
    logic [GA_W:0]         ngates_d;

    logic [1:0]            opa;
    logic [1:0]            opb;
    logic [1:0]            opc;
    logic [1:0]            opo;
    logic                  has_g;
    logic                  last_g;
    logic                  gate_v;
    logic                  obit;
    logic                  op_err;
    logic [NUM_GATES-1:0]  gv_nx;

    // Resolve one select to {err, value}: gates at or past lim read as 0 with err.
    function automatic logic [1:0] op_val(
        input logic [SEL_MAX_W-1:0]  s,
        input int                    lim,
        input logic [NUM_INPUTS-1:0] x,
        input logic [NUM_GATES-1:0]  gv
    );
        int         si;
        logic [1:0] r;
        si = int'(s);
        r  = 2'b00;
        if (si == SEL_CONST0) begin
            r = 2'b00;
        end else if (si > NUM_INPUTS + NUM_GATES) begin
            r = 2'b10;
        end
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (si == SEL_X_BASE + k) begin
                r = {1'b0, x[k]};
            end
        end
        for (int k = 0; k < NUM_GATES; k++) begin
            if (si == SEL_X_BASE + NUM_INPUTS + k) begin
                r = (k < lim) ? {1'b0, gv[k]} : 2'b10;
            end
        end
        return r;
    endfunction

    assign cfg_wr = cfg_we && (state_q == ST_IDLE);
    assign ga     = g_q[GA_W-1:0];

    assign ngates_d = (cfg_ngates > (GA_W+1)'(NUM_GATES))
                    ? (GA_W+1)'(NUM_GATES) : cfg_ngates;

    // Widen the incoming operand selects into the stored gate record.
    always_comb begin
        cfg_gc       = '0;
        cfg_gc.sel_a = SEL_MAX_W'(cfg_sel[SEL_W-1:0]);
        cfg_gc.sel_b = SEL_MAX_W'(cfg_sel[2*SEL_W-1:SEL_W]);
        cfg_gc.sel_c = SEL_MAX_W'(cfg_sel[3*SEL_W-1:2*SEL_W]);
        cfg_gc.inv_a = cfg_inv[0];
        cfg_gc.inv_b = cfg_inv[1];
        cfg_gc.inv_c = cfg_inv[2];
    end

    mig_gate_ram #(
        .NUM_GATES (NUM_GATES),
        .GA_W      (GA_W)
    ) u_ram (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (cfg_wr),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_gc),
        .rd_addr_i (ga),
        .rd_data_o (gc)
    );

    // Evaluate the current gate and, on the last one, the output signal.
    always_comb begin
        opa    = op_val(gc.sel_a, int'(g_q), pat_q, gv_q);
        opb    = op_val(gc.sel_b, int'(g_q), pat_q, gv_q);
        opc    = op_val(gc.sel_c, int'(g_q), pat_q, gv_q);
        gate_v = maj3(opa[0] ^ gc.inv_a,
                      opb[0] ^ gc.inv_b,
                      opc[0] ^ gc.inv_c);
        has_g  = (ngates_q != '0);
        last_g = !has_g || (g_q == ngates_q - (GA_W+1)'(1));
        gv_nx  = gv_q;
        if (has_g) begin
            gv_nx[ga] = gate_v;
        end
        opo    = op_val(SEL_MAX_W'(out_sel_q), int'(ngates_q),
                        pat_q, gv_nx);
        obit   = opo[0] ^ out_inv_q;
        op_err = has_g && (opa[1] | opb[1] | opc[1]);
    end

    // Control FSM with config latch, evaluation sequencing and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            pat_q       <= '0;
            mode_q      <= 1'b0;
            gv_q        <= '0;
            ngates_q    <= '0;
            out_sel_q   <= '0;
            out_inv_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_tt_q    <= '0;
            ref_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_we) begin
                        ngates_q  <= ngates_d;
                        out_sel_q <= cfg_out_sel;
                        out_inv_q <= cfg_out_inv;
                        if (cfg_addr == '0) begin
                            ref_err_q <= 1'b0;
                        end
                    end
                    if (in_valid) begin
                        mode_q     <= in_mode;
                        pat_q      <= in_mode ? '0 : in_x;
                        out_tt_q   <= '0;
                        g_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    gv_q <= gv_nx;
                    if (op_err || (last_g && opo[1])) begin
                        ref_err_q <= 1'b1;
                    end
                    if (!last_g) begin
                        g_q <= g_q + (GA_W+1)'(1);
                    end else begin
                        g_q <= '0;
                        if (!mode_q) begin
                            out_bit_q <= obit;
                            state_q   <= ST_DONE;
                        end else begin
                            out_tt_q[pat_q] <= obit;
                            if (pat_q == '1) begin
                                state_q <= ST_DONE;
                            end else begin
                                pat_q <= pat_q + NUM_INPUTS'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_tt    = out_tt_q;
    assign ref_err   = ref_err_q;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Scoreboard bench for mig_seq_eval: stimulus pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_mig_seq_eval;

    localparam int NI = 7;
    localparam int NG = 8;
    localparam int SW = 4;
    localparam int GW = 3;
    localparam int TW = 128;

    localparam logic [TW-1:0] TT_REF =
        128'hfeeeeee8fae8e880fee8e8a0e8888880;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [GW-1:0] cfg_addr = '0;
    logic [3*SW-1:0] cfg_sel = '0;
    logic [2:0]    cfg_inv = '0;
    logic [GW:0]   cfg_ngates = '0;
    logic [SW-1:0] cfg_out_sel = '0;
    logic          cfg_out_inv = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [NI-1:0] in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_bit;
    logic [TW-1:0] out_tt;
    logic          ref_err;

    typedef struct {
        logic          mode;
        logic          eb;
        logic [TW-1:0] et;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Netlist from the reference classification function: select codes
    // x_i = 1+i, gate k = 8+k.
    int net_a[7] = '{4, 4, 3, 1, 1, 8, 5};
    int net_b[7] = '{6, 5, 6, 2, 3, 11, 11};
    int net_c[7] = '{7, 7, 9, 10, 4, 12, 13};

    mig_seq_eval #(
        .NUM_INPUTS (NI),
        .NUM_GATES  (NG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_sel     (cfg_sel),
        .cfg_inv     (cfg_inv),
        .cfg_ngates  (cfg_ngates),
        .cfg_out_sel (cfg_out_sel),
        .cfg_out_inv (cfg_out_inv),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_tt      (out_tt),
        .ref_err     (ref_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [TW-1:0] act,
                         input logic [TW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input int a, input int sc, input int sbs,
                             input int sa, input logic [2:0] inv,
                             input int ng, input int os, input logic oi);
        cfg_we      = 1'b1;
        cfg_addr    = GW'(a);
        cfg_sel     = {SW'(sc), SW'(sbs), SW'(sa)};
        cfg_inv     = inv;
        cfg_ngates  = (GW+1)'(ng);
        cfg_out_sel = SW'(os);
        cfg_out_inv = oi;
        @(posedge clk); #1;
        cfg_we      = 1'b0;
    endtask

    task automatic load_netlist();
        for (int i = 0; i < 7; i++) begin
            cfg_write(i, net_c[i], net_b[i], net_a[i], 3'b000, 7, 14, 1'b0);
        end
    endtask

    task automatic request(input logic mode, input logic [NI-1:0] x,
                           input logic eb, input logic [TW-1:0] et,
                           input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready: in_ready got 0 expected 1");
        end else begin
            in_valid = 1'b1;
            in_mode  = mode;
            in_x     = x;
            @(posedge clk); #1;
            e.mode = mode;
            e.eb   = eb;
            e.et   = et;
            e.lat  = lat;
            e.acc  = cyc;
            sbq.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (!in_ready && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: in_ready got 0 expected 1 within %0d", lim);
        end
    endtask

    // Monitor: latency on first out_valid, data on the handshake.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sbq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got out_valid 1 expected 0");
                    end else begin
                        check("latency", TW'(cyc - sbq[0].acc), TW'(sbq[0].lat));
                    end
                end
                if (out_ready) begin
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        if (e.mode) check("out_tt", out_tt, e.et);
                        else        check("out_bit", TW'(out_bit), TW'(e.eb));
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation got no end expected end");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int n;
        #12;
        check("rst_out_valid", TW'(out_valid), TW'(1'b0));
        check("rst_in_ready", TW'(in_ready), TW'(1'b1));
        check("rst_out_bit", TW'(out_bit), TW'(1'b0));
        check("rst_out_tt", out_tt, '0);
        check("rst_ref_err", TW'(ref_err), TW'(1'b0));
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty netlist: output is const0 inverted.
        cfg_write(0, 0, 0, 0, 3'b000, 0, 0, 1'b1);
        request(1'b0, '0, 1'b1, '0, 2);
        wait_idle(50);

        // Full sweep of the reference netlist.
        load_netlist();
        request(1'b1, '0, 1'b0, TT_REF, 897);
        wait_idle(1200);
        check("sweep_ref_err", TW'(ref_err), TW'(1'b0));

        request(1'b0, 7'h7F, 1'b1, '0, 8);
        wait_idle(50);
        request(1'b0, 7'h00, 1'b0, '0, 8);
        wait_idle(50);
        request(1'b0, 7'h07, 1'b1, '0, 8);
        wait_idle(50);

        // Back-pressure in DONE, plus a config write issued during EVAL.
        out_ready = 1'b0;
        request(1'b0, 7'h7F, 1'b1, '0, 8);
        cfg_write(6, 0, 0, 0, 3'b000, 1, 0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", TW'(out_valid), TW'(1'b1));
            check("hold_bit", TW'(out_bit), TW'(1'b1));
            check("hold_in_ready", TW'(in_ready), TW'(1'b0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle(50);
        request(1'b0, 7'h7F, 1'b1, '0, 8);
        wait_idle(50);

        // Self reference on gate 0.
        cfg_write(0, 0, 0, 8, 3'b000, 1, 8, 1'b0);
        request(1'b0, 7'h00, 1'b0, '0, 2);
        wait_idle(50);
        check("self_ref_err", TW'(ref_err), TW'(1'b1));
        cfg_write(1, 0, 0, 0, 3'b000, 0, 0, 1'b1);
        check("sticky_after_wr1", TW'(ref_err), TW'(1'b1));
        request(1'b0, 7'h00, 1'b1, '0, 2);
        wait_idle(50);
        check("sticky_after_req", TW'(ref_err), TW'(1'b1));
        cfg_write(0, net_c[0], net_b[0], net_a[0], 3'b000, 7, 14, 1'b0);
        check("ref_err_clear", TW'(ref_err), TW'(1'b0));

        // Abort a sweep with reset.
        load_netlist();
        request(1'b1, '0, 1'b0, TT_REF, 897);
        repeat (300) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", TW'(out_valid), TW'(1'b0));
        check("abort_out_tt", out_tt, '0);
        check("abort_in_ready", TW'(in_ready), TW'(1'b1));
        sbq.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Config cleared by reset: ngates 0, out_sel const0, no inversion.
        request(1'b0, 7'h7F, 1'b0, '0, 2);
        wait_idle(50);
        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", TW'(sbq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
